// File: rtl/axi_lite_regs_pkg.sv
// Shared constants for the AXI4-Lite register bank: register offsets,
// response codes, CTRL and IRQ bit positions, and small decode helpers.
package axi_lite_regs_pkg;

    localparam logic [4:0] OFF_ID         = 5'h00;
    localparam logic [4:0] OFF_SCRATCH    = 5'h04;
    localparam logic [4:0] OFF_CTRL       = 5'h08;
    localparam logic [4:0] OFF_COUNT      = 5'h0C;
    localparam logic [4:0] OFF_COMPARE    = 5'h10;
    localparam logic [4:0] OFF_IRQ_STATUS = 5'h14;
    localparam logic [4:0] OFF_IRQ_EN     = 5'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_CNT_EN  = 8;
    localparam int CTRL_CNT_CLR = 9;

    localparam int IRQ_MATCH = 0;
    localparam int IRQ_OVF   = 1;

    // Word slot 7 (0x1C) is the only hole inside the decoded window.
    function automatic logic slot_mapped(input logic [2:0] slot);
        return slot != 3'd7;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] byte_mask);
        return (old_val & ~byte_mask) | (new_val & byte_mask);
    endfunction

endpackage

// File: rtl/axi_lite_regs_timer.sv
// Free-running 32-bit counter with compare-match and overflow status bits.
// Hardware sets take priority over a same-cycle W1C clear.
module axi_lite_regs_timer
    import axi_lite_regs_pkg::*;
(
    input  logic        aclk,
    input  logic        areset,
    input  logic        cnt_en,
    input  logic        cnt_clr,
    input  logic [31:0] compare,
    input  logic [1:0]  w1c_mask,
    output logic [31:0] count,
    output logic [1:0]  status
);

    logic [31:0] count_reg;
    logic [1:0]  status_reg;
    logic [1:0]  status_set;

    // A clear on the wrap cycle suppresses the increment, so no overflow either.
    always_comb begin
        status_set            = '0;
        status_set[IRQ_MATCH] = cnt_en && (count_reg == compare);
        status_set[IRQ_OVF]   = cnt_en && !cnt_clr && (count_reg == 32'hFFFF_FFFF);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count_reg  <= '0;
            status_reg <= '0;
        end else begin
            if (cnt_clr) begin
                count_reg <= '0;
            end else if (cnt_en) begin
                count_reg <= count_reg + 32'd1;
            end
            status_reg <= (status_reg & ~w1c_mask) | status_set;
        end
    end

    assign count  = count_reg;
    assign status = status_reg;

endmodule

// File: rtl/axi_lite_regs.sv
// AXI4-Lite slave register bank: ID, scratch, LED/counter control, compare
// and interrupt registers. AW and W are buffered independently, then committed.
module axi_lite_regs
    import axi_lite_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] VERSION    = 32'h0001_0000,
    parameter int          LED_WIDTH  = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  irq
);

    localparam logic [31:0] CTRL_MASK = (32'h1 << CTRL_CNT_EN) | ((32'h1 << LED_WIDTH) - 32'h1);

    logic        ready_en_reg;
    logic        aw_held_reg, w_held_reg;
    logic [4:0]  aw_off_reg;
    logic        aw_ok_reg;
    logic [31:0] w_data_reg;
    logic [3:0]  w_strb_reg;
    logic        bvalid_reg, rvalid_reg;
    logic [1:0]  bresp_reg, rresp_reg;
    logic [31:0] rdata_reg;
    logic [31:0] scratch_reg, ctrl_reg, compare_reg;
    logic [1:0]  irq_en_reg;
    logic        irq_reg;

    logic [31:0] count;
    logic [1:0]  status;
    logic [31:0] strb_mask;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic        aw_ok, ar_ok;
    logic [4:0]  rd_off;
    logic [31:0] rd_data;
    logic        cnt_clr;
    logic [1:0]  w1c_mask;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Readies stay low in reset and rise on the first edge afterwards.
    assign s_axi_awready = ready_en_reg & ~aw_held_reg;
    assign s_axi_wready  = ready_en_reg & ~w_held_reg;
    assign s_axi_arready = ready_en_reg & ~rvalid_reg;

    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign commit = aw_held_reg & w_held_reg & ~bvalid_reg;

    assign aw_ok  = (s_axi_awaddr[ADDR_WIDTH-1:5] == '0) && slot_mapped(s_axi_awaddr[4:2]);
    assign ar_ok  = (s_axi_araddr[ADDR_WIDTH-1:5] == '0) && slot_mapped(s_axi_araddr[4:2]);
    assign rd_off = {s_axi_araddr[4:2], 2'b00};

    for (genvar gi = 0; gi < 4; gi++) begin : g_strb
        assign strb_mask[8*gi +: 8] = {8{w_strb_reg[gi]}};
    end

    assign cnt_clr  = commit && aw_ok_reg && (aw_off_reg == OFF_CTRL)
                      && w_strb_reg[1] && w_data_reg[CTRL_CNT_CLR];
    assign w1c_mask = (commit && aw_ok_reg && (aw_off_reg == OFF_IRQ_STATUS))
                      ? (w_data_reg[1:0] & {2{w_strb_reg[0]}}) : 2'b00;

    always_comb begin
        rd_data = '0;
        if (ar_ok) begin
            case (rd_off)
                OFF_ID:         rd_data = VERSION;
                OFF_SCRATCH:    rd_data = scratch_reg;
                OFF_CTRL:       rd_data = ctrl_reg;
                OFF_COUNT:      rd_data = count;
                OFF_COMPARE:    rd_data = compare_reg;
                OFF_IRQ_STATUS: rd_data = {30'd0, status};
                OFF_IRQ_EN:     rd_data = {30'd0, irq_en_reg};
                default:        rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_en_reg <= 1'b0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_off_reg   <= '0;
            aw_ok_reg    <= 1'b0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            rvalid_reg   <= 1'b0;
            rresp_reg    <= RESP_OKAY;
            rdata_reg    <= '0;
            scratch_reg  <= '0;
            ctrl_reg     <= '0;
            compare_reg  <= '0;
            irq_en_reg   <= '0;
            irq_reg      <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;

            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_off_reg  <= {s_axi_awaddr[4:2], 2'b00};
                aw_ok_reg   <= aw_ok;
            end else if (commit) begin
                aw_held_reg <= 1'b0;
            end

            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= s_axi_wdata;
                w_strb_reg <= s_axi_wstrb;
            end else if (commit) begin
                w_held_reg <= 1'b0;
            end

            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= aw_ok_reg ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end

            // Unmapped commits fall through every case below untouched.
            if (commit && aw_ok_reg) begin
                case (aw_off_reg)
                    OFF_SCRATCH: scratch_reg <= merge_bytes(scratch_reg, w_data_reg, strb_mask);
                    OFF_CTRL:    ctrl_reg    <= merge_bytes(ctrl_reg, w_data_reg, strb_mask) & CTRL_MASK;
                    OFF_COMPARE: compare_reg <= merge_bytes(compare_reg, w_data_reg, strb_mask);
                    OFF_IRQ_EN:  if (w_strb_reg[0]) irq_en_reg <= w_data_reg[1:0];
                    default:     ;
                endcase
            end

            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data;
                rresp_reg  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_reg && s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end

            irq_reg <= |(status & irq_en_reg);
        end
    end

    axi_lite_regs_timer u_timer (
        .aclk     (aclk),
        .areset   (areset),
        .cnt_en   (ctrl_reg[CTRL_CNT_EN]),
        .cnt_clr  (cnt_clr),
        .compare  (compare_reg),
        .w1c_mask (w1c_mask),
        .count    (count),
        .status   (status)
    );

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rdata  = rdata_reg;
    assign s_axi_rresp  = rresp_reg;
    assign led          = ctrl_reg[LED_WIDTH-1:0];
    assign irq          = irq_reg;

endmodule

// File: tb/tb_axi_lite_regs.sv
// Directed bench for axi_lite_regs: a register access table followed by
// hand-timed sequences for buffering, stalls, interrupts and mid-transfer reset.
module tb_axi_lite_regs;

    logic        aclk = 1'b0;
    logic        areset;
    logic [11:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [3:0]  led;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axi_lite_regs dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .led(led), .irq(irq)
    );

    typedef struct {
        bit          is_wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, got);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int n = 0;
        @(negedge aclk);
        awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge aclk);
            n++;
            if (aw_fire) begin aw_done = 1; awvalid = 0; end
            if (w_fire)  begin w_done = 1;  wvalid = 0;  end
        end
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        ok   = bvalid && aw_done && w_done;
        resp = bresp;
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output bit ok);
        int n = 0;
        @(negedge aclk);
        araddr = a; arvalid = 1; rready = 1;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        @(negedge aclk);
        arvalid = 0;
        ok   = rvalid && (n < 50);
        d    = rdata;
        resp = rresp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, c1, c2;
        logic [1:0]  r;
        bit          ok;
        int          first_k, n;

        areset = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge aclk);
        chk("reset awready", awready, 0);
        chk("reset wready", wready, 0);
        chk("reset arready", arready, 0);
        chk("reset bvalid", bvalid, 0);
        chk("reset rvalid", rvalid, 0);
        chk("reset rdata", rdata, 0);
        chk("reset led", led, 0);
        chk("reset irq", irq, 0);
        areset = 0;
        @(negedge aclk);
        chk("post-reset awready", awready, 1);

        // W arrives three cycles before AW; bvalid follows the AW handshake by one cycle.
        bready = 0; wdata = 32'hA5A5_5A5A; wstrb = 4'b0101; wvalid = 1;
        chk("early W wready", wready, 1);
        @(negedge aclk);
        wvalid = 0;
        chk("W held wready", wready, 0);
        chk("W held awready", awready, 1);
        chk("W held bvalid", bvalid, 0);
        @(negedge aclk);
        @(negedge aclk);
        awaddr = 12'h004; awvalid = 1;
        @(negedge aclk);
        awvalid = 0;
        chk("AW hs edge bvalid", bvalid, 0);
        @(negedge aclk);
        chk("AW+1 bvalid", bvalid, 1);
        chk("AW+1 bresp", bresp, 0);
        @(negedge aclk);
        chk("bvalid held", bvalid, 1);
        bready = 1;
        @(negedge aclk);
        chk("bvalid dropped", bvalid, 0);

        vecs[0]  = '{0, 12'h000, 32'h0,         4'h0, 32'h0001_0000, 2'b00};
        vecs[1]  = '{0, 12'h004, 32'h0,         4'h0, 32'h00A5_005A, 2'b00};
        vecs[2]  = '{0, 12'h008, 32'h0,         4'h0, 32'h0,         2'b00};
        vecs[3]  = '{1, 12'h010, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[4]  = '{0, 12'h010, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        vecs[5]  = '{1, 12'h010, 32'hFFFF_FFFF, 4'hA, 32'h0,         2'b00};
        vecs[6]  = '{0, 12'h010, 32'h0,         4'h0, 32'hFF34_FF78, 2'b00};
        vecs[7]  = '{1, 12'h000, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[8]  = '{0, 12'h000, 32'h0,         4'h0, 32'h0001_0000, 2'b00};
        vecs[9]  = '{1, 12'h018, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vecs[10] = '{0, 12'h018, 32'h0,         4'h0, 32'h3,         2'b00};
        vecs[11] = '{1, 12'h018, 32'h0,         4'hF, 32'h0,         2'b00};
        vecs[12] = '{0, 12'h018, 32'h0,         4'h0, 32'h0,         2'b00};
        vecs[13] = '{0, 12'h01C, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[14] = '{1, 12'h040, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        vecs[15] = '{1, 12'h01C, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        vecs[16] = '{0, 12'h040, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[17] = '{0, 12'h004, 32'h0,         4'h0, 32'h00A5_005A, 2'b00};
        vecs[18] = '{1, 12'h004, 32'hCAFE_F00D, 4'hC, 32'h0,         2'b00};
        vecs[19] = '{0, 12'h004, 32'h0,         4'h0, 32'hCAFE_005A, 2'b00};
        vecs[20] = '{0, 12'h014, 32'h0,         4'h0, 32'h0,         2'b00};
        vecs[21] = '{0, 12'h00C, 32'h0,         4'h0, 32'h0,         2'b00};
        vecs[22] = '{1, 12'h008, 32'hFFFF_FCFA, 4'h1, 32'h0,         2'b00};
        vecs[23] = '{0, 12'h008, 32'h0,         4'h0, 32'h0000_000A, 2'b00};
        vecs[24] = '{0, 12'h00C, 32'h0,         4'h0, 32'h0,         2'b00};

        for (int i = 0; i < 25; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, ok);
                chk($sformatf("v%0d wr 0x%03h done", i, vecs[i].addr), ok, 1);
                chk($sformatf("v%0d wr 0x%03h bresp", i, vecs[i].addr), r, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, d, r, ok);
                chk($sformatf("v%0d rd 0x%03h rvalid+1", i, vecs[i].addr), ok, 1);
                chk($sformatf("v%0d rd 0x%03h rdata", i, vecs[i].addr), d, vecs[i].exp_data);
                chk($sformatf("v%0d rd 0x%03h rresp", i, vecs[i].addr), r, vecs[i].exp_resp);
            end
        end
        chk("led after ctrl byte0", led, 4'hA);

        // Counter runs; back-to-back reads are two edges apart, the stalled one two more.
        axi_write(12'h008, 32'h0000_0105, 4'hF, r, ok);
        chk("ctrl 0x105 led", led, 4'b0101);
        axi_read(12'h00C, c1, r, ok);
        axi_read(12'h00C, c2, r, ok);
        chk("count delta", c2 - c1, 2);
        @(negedge aclk);
        araddr = 12'h00C; arvalid = 1; rready = 0;
        @(negedge aclk);
        arvalid = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d rvalid", k), rvalid, 1);
            chk($sformatf("stall%0d rdata", k), rdata, c2 + 32'd2);
            chk($sformatf("stall%0d arready", k), arready, 0);
            @(negedge aclk);
        end
        rready = 1;
        @(negedge aclk);
        chk("stall release rvalid", rvalid, 0);

        // Compare match: count restarts at 0 on the commit edge, matches 20 cycles later.
        axi_write(12'h008, 32'h0000_0005, 4'hF, r, ok);
        axi_write(12'h010, 32'd20, 4'hF, r, ok);
        axi_write(12'h014, 32'h3, 4'hF, r, ok);
        axi_write(12'h018, 32'h1, 4'hF, r, ok);
        axi_read(12'h014, d, r, ok);
        chk("status cleared", d, 0);
        chk("irq idle", irq, 0);
        axi_write(12'h008, 32'h0000_0305, 4'hF, r, ok);
        first_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge aclk);
            if (irq && first_k == 0) first_k = k;
        end
        chk("irq rise cycle", first_k, 22);
        axi_read(12'h014, d, r, ok);
        chk("status match", d, 1);
        axi_read(12'h008, d, r, ok);
        chk("cnt_clr reads 0", d, 32'h0000_0105);
        axi_write(12'h014, 32'h1, 4'h0, r, ok);
        axi_read(12'h014, d, r, ok);
        chk("W1C no strobe", d, 1);
        axi_write(12'h014, 32'h1, 4'h1, r, ok);
        @(negedge aclk);
        chk("irq after W1C", irq, 0);
        axi_read(12'h014, d, r, ok);
        chk("status after W1C", d, 0);

        // Reset lands while a write response is pending.
        @(negedge aclk);
        awaddr = 12'h004; awvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1; bready = 0;
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge aclk); n++; end
        chk("pre-reset bvalid", bvalid, 1);
        areset = 1;
        #1;
        chk("async rst bvalid", bvalid, 0);
        chk("async rst led", led, 0);
        chk("async rst awready", awready, 0);
        @(negedge aclk);
        areset = 0;
        #1;
        chk("release awready", awready, 0);
        @(negedge aclk);
        chk("release+1 awready", awready, 1);
        axi_read(12'h004, d, r, ok);
        chk("rst scratch", d, 0);
        axi_read(12'h010, d, r, ok);
        chk("rst compare", d, 0);
        axi_read(12'h00C, d, r, ok);
        chk("rst count", d, 0);
        axi_read(12'h018, d, r, ok);
        chk("rst irq_en", d, 0);
        axi_write(12'h004, 32'h1122_3344, 4'hF, r, ok);
        chk("post-rst write done", ok, 1);
        chk("post-rst bresp", r, 0);
        axi_read(12'h004, d, r, ok);
        chk("post-rst readback", d, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
